// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock period meter and its helpers.
package clk_meas_pkg;

   localparam int CNT_W_DEF = 14;
   localparam int CNT_SAT_DEF = (1 << CNT_W_DEF) - 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_MEASURE,
      ST_STALL
   } meas_state_e;

   function automatic int unsigned cnt_sat(input int w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/clk_period_meter_if.sv
// Measurement bus: stimulus/soft-restart inputs and published results.
interface clk_period_meter_if
   import clk_meas_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) ();

   logic             sig_in;
   logic             clear;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             locked;
   logic             stalled;

   modport master (
      output sig_in, clear,
      input  period, high_time, meas_valid, locked, stalled
   );

   modport slave (
      input  sig_in, clear,
      output period, high_time, meas_valid, locked, stalled
   );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer with edge detection and a fill flag that marks when s
// carries a real sample rather than the reset zero.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic sig_in,
   output logic s,
   output logic s_vld,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] vld_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         sync_q <= '0;
         vld_q  <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s     = sync_q[SYNC_STAGES-1];
   assign s_vld = vld_q[SYNC_STAGES-1];
   assign rise  = s & ~prev_q;
   assign fall  = ~s & prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow input in clk cycles, with lock and
// stall status derived from successive measurements.
module clk_period_meter
   import clk_meas_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input logic               clk,
   input logic               reset,
   clk_period_meter_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_sat(CNT_W));
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic        s, s_vld, rise, fall;
   meas_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_time_q, high_time_d;
   logic        valid_q, valid_d;
   logic        locked_q, locked_d;
   logic        stalled_q, stalled_d;
   logic        have_prev_q, have_prev_d;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .clear (bus.clear),
      .sig_in(bus.sig_in),
      .s     (s),
      .s_vld (s_vld),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge clk) begin
      if (!reset || bus.clear) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hi_cap_q    <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         stalled_q   <= 1'b0;
         have_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_cap_q    <= hi_cap_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
         stalled_q   <= stalled_d;
         have_prev_q <= have_prev_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hi_cap_d    = hi_cap_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      valid_d     = 1'b0;
      locked_d    = locked_q;
      stalled_d   = stalled_q;
      have_prev_d = have_prev_q;
      case (state_q)
         // Only a genuinely sampled low arms; the reset zero in the synchronizer does not count.
         ST_IDLE: if (s_vld && !s) state_d = ST_ARM;
         ST_ARM: begin
            if (rise) begin
               state_d = ST_MEASURE;
               cnt_d   = CNT_ONE;
            end
         end
         ST_MEASURE: begin
            if (rise) begin
               cnt_d       = CNT_ONE;
               period_d    = cnt_q;
               high_time_d = hi_cap_q;
               valid_d     = 1'b1;
               locked_d    = have_prev_q && (cnt_q == period_q) && (hi_cap_q == high_time_q);
               have_prev_d = 1'b1;
            end else begin
               if (fall) hi_cap_d = cnt_q;
               if (cnt_q >= CNT_SAT - CNT_ONE) begin
                  cnt_d       = CNT_SAT;
                  state_d     = ST_STALL;
                  stalled_d   = 1'b1;
                  locked_d    = 1'b0;
                  have_prev_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         ST_STALL: begin
            if (rise) begin
               state_d   = ST_MEASURE;
               cnt_d     = CNT_ONE;
               stalled_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.period     = period_q;
   assign bus.high_time  = high_time_q;
   assign bus.meas_valid = valid_q;
   assign bus.locked     = locked_q;
   assign bus.stalled    = stalled_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized bench for clk_period_meter against a timestamp-based reference of
// input rise/fall times.
module tb_clk_period_meter;
   import clk_meas_pkg::*;

   localparam int CNT_W = 8;
   localparam int SYNC  = 2;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   clk_period_meter_if #(.CNT_W(CNT_W)) bus ();

   clk_period_meter #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   typedef struct {
      bit pub;
      bit st_set;
      bit st_clr;
      bit lck;
      int p;
      int h;
   } rec_t;

   // Reference: works on raw input sample times; results surface SYNC edges later.
   localparam int M_GATE = 0, M_ARM = 1, M_MEAS = 2, M_STALL = 3;
   int   n_checks = 0;
   int   n_errors = 0;
   int   e = 0;
   int   mode = M_GATE;
   bit   last_v = 0;
   int   rise_t = 0;
   int   hi_len = 0;
   int   prev_p = 0, prev_h = 0;
   bit   have_prev = 0;
   rec_t pipe [SYNC];
   int   exp_p = 0, exp_h = 0;
   bit   exp_v = 0, exp_l = 0, exp_s = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", tag, e, obs, exp);
      end
   endtask

   task automatic model_edge(input bit v, input bit clr, input bit rst);
      rec_t r;
      bit   rs, fl;
      e++;
      r = '{default: 0};
      if (rst || clr) begin
         for (int i = 0; i < SYNC; i++) pipe[i] = '{default: 0};
         exp_p = 0; exp_h = 0; exp_v = 0; exp_l = 0; exp_s = 0;
         mode = M_GATE; last_v = 0; hi_len = 0; have_prev = 0;
         prev_p = 0; prev_h = 0;
         return;
      end
      rs = v && !last_v;
      fl = !v && last_v;
      case (mode)
         M_GATE: if (!v) mode = M_ARM;
         M_ARM: if (rs) begin mode = M_MEAS; rise_t = e; end
         M_MEAS: begin
            if (rs) begin
               r.pub = 1;
               r.p   = e - rise_t;
               r.h   = hi_len;
               r.lck = have_prev && (r.p == prev_p) && (r.h == prev_h);
               prev_p = r.p; prev_h = r.h; have_prev = 1;
               rise_t = e;
            end else begin
               if (fl) hi_len = e - rise_t;
               if (e - rise_t >= MAXC - 1) begin
                  mode = M_STALL; r.st_set = 1; have_prev = 0;
               end
            end
         end
         default: if (rs) begin mode = M_MEAS; rise_t = e; r.st_clr = 1; end
      endcase
      last_v = v;
      exp_v = 0;
      if (pipe[SYNC-1].pub) begin
         exp_v = 1; exp_p = pipe[SYNC-1].p; exp_h = pipe[SYNC-1].h; exp_l = pipe[SYNC-1].lck;
      end
      if (pipe[SYNC-1].st_set) begin exp_s = 1; exp_l = 0; end
      if (pipe[SYNC-1].st_clr) exp_s = 0;
      for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = r;
   endtask

   task automatic tick(input bit v, input bit clr, input bit rst);
      bus.sig_in = v;
      bus.clear  = clr;
      reset      = !rst;
      @(posedge clk);
      model_edge(v, clr, rst);
      #1;
      check_eq("meas_valid", bus.meas_valid, exp_v);
      check_eq("stalled", bus.stalled, exp_s);
      check_eq("locked", bus.locked, exp_l);
      check_eq("period", bus.period, exp_p);
      check_eq("high_time", bus.high_time, exp_h);
      if (exp_v)
         $display("meas cycle=%0d period=%0d high_time=%0d locked=%0b stalled=%0b",
                  e, bus.period, bus.high_time, bus.locked, bus.stalled);
   endtask

   task automatic wave(input int hi, input int lo, input int n);
      for (int k = 0; k < n; k++) begin
         repeat (hi) tick(1'b1, 1'b0, 1'b0);
         repeat (lo) tick(1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      for (int i = 0; i < SYNC; i++) pipe[i] = '{default: 0};
      bus.sig_in = 1'b0;
      bus.clear  = 1'b0;
      reset      = 1'b0;

      // Steady square wave, ratio 5
      repeat (4) tick(1'b0, 1'b0, 1'b1);
      repeat (3) tick(1'b0, 1'b0, 1'b0);
      wave(5, 5, 6);

      // Minimum period
      wave(1, 1, 8);

      // Saturation, then recovery at period 8
      repeat (4) tick(1'b1, 1'b0, 1'b0);
      repeat (300) tick(1'b0, 1'b0, 1'b0);
      wave(4, 4, 4);

      // Input high across reset release
      repeat (3) tick(1'b1, 1'b0, 1'b1);
      repeat (20) tick(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         repeat (6) tick(1'b0, 1'b0, 1'b0);
         repeat (6) tick(1'b1, 1'b0, 1'b0);
      end
      repeat (6) tick(1'b0, 1'b0, 1'b0);

      // Period change while locked
      wave(5, 5, 4);
      wave(7, 5, 1);
      wave(5, 5, 4);

      // Clear landing on the cycle the rise is detected
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      repeat (2) tick(1'b1, 1'b0, 1'b0);
      repeat (5) tick(1'b0, 1'b0, 1'b0);
      wave(5, 5, 4);

      // Random waveforms with occasional clears and stalls
      for (int k = 0; k < 60; k++) begin
         int hi, lo, cp;
         hi = $urandom_range(1, 12);
         lo = ($urandom_range(0, 14) == 0) ? $urandom_range(250, 270) : $urandom_range(1, 12);
         cp = ($urandom_range(0, 7) == 0) ? $urandom_range(0, hi - 1) : -1;
         for (int i = 0; i < hi; i++) tick(1'b1, (i == cp), 1'b0);
         repeat (lo) tick(1'b0, 1'b0, 1'b0);
         if ($urandom_range(0, 3) == 0) wave(hi, lo > 20 ? 5 : lo, 3);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow periodic input in cycles of the system clock. It is the measuring counterpart of the multi-output clock divider: it recovers the division ratio from a divided or external square wave. Typical uses are self-check of divider taps and tempo/rate detection of incoming clock-like signals. The input is synchronized internally. Results are published with a one-cycle valid pulse plus lock and stall status.

## Interface
- `CNT_W`, 14: width of the cycle counter and of both result ports; covers a divider period of 2×4095 = 8190.
- `SYNC_STAGES`, 2: synchronizer depth on `sig_in`; legal range is 2 or more.
- `clk` input, 1 bit: system clock; every flop runs on its rising edge.
- `reset` input, 1 bit: synchronous, active-low reset.
- `sig_in` input, 1 bit: signal under measurement; may be asynchronous to `clk`.
- `clear` input, 1 bit: synchronous soft restart with the same effect as reset.
- `period` output, `CNT_W` bits: `clk` cycles between the last two rising edges.
- `high_time` output, `CNT_W` bits: `clk` cycles from a rising edge to the following falling edge.
- `meas_valid` output, 1 bit: one-cycle pulse when `period` and `high_time` update.
- `locked` output, 1 bit: high while consecutive measurements are identical.
- `stalled` output, 1 bit: high when the counter has saturated and no edge has arrived.

## Operation
- **Edge detection:** `s` is the last synchronizer stage and `prev` is `s` delayed by one cycle. `rise = s & ~prev`; `fall = ~s & prev`.
- **States:**
  - IDLE: wait for `s==0`, then go to ARM.
  - ARM: on `rise`, go to MEASURE.
  - MEASURE: measuring.
  - STALL: on `rise`, go to MEASURE.
- **Counter `cnt`:**
  - Loads 1 on every `rise` in ARM, MEASURE or STALL.
  - Otherwise increments by 1 in MEASURE.
  - Saturates at 2^CNT_W−1.
- **On `fall` in MEASURE:** `hi_cap <= cnt`.
- **On `rise` in MEASURE:** `period <= cnt`, `high_time <= hi_cap`, `meas_valid <= 1` for one cycle.
- **Edge-to-edge counts:** rises at cycles t and t+P give `period = P`; a fall at t+H gives `high_time = H`.
- **Saturation:** when `cnt` reaches 2^CNT_W−1 in MEASURE:
  - Go to STALL; set `stalled=1` and `locked=0`.
  - The rise that leaves STALL produces no `meas_valid`.
  - `stalled` clears on that rise.
- **Lock:** compare each new (`period`, `high_time`) pair with the previous published pair.
  - Equal: `locked <= 1`.
  - Different: `locked <= 0`.
  - The first measurement after IDLE or STALL never sets `locked`.
- **Reset/clear values:** all outputs 0, `cnt=0`, `hi_cap=0`, synchronizer flops 0, state IDLE.
- **Priority:** `reset` over `clear` over edge events. An edge in the same cycle as `clear` is discarded.
- **Input high at reset release:** no measurement starts until `sig_in` has been seen low (IDLE gate).

## Timing
- Latency from a `sig_in` transition sampled at clock edge k to the detected event: `rise`/`fall` is active in the cycle after edge k+SYNC_STAGES−1.
- Registered results and the `meas_valid` pulse appear at edge k+SYNC_STAGES, i.e. 2 edges for the default depth.
- `meas_valid` is at most one cycle wide. With the minimum period (2) it may pulse every second cycle.
- **Minimum resolvable input:** high ≥ 1 cycle and low ≥ 1 cycle after synchronization. Shorter pulses may be lost without error.
- `locked` and `stalled` change in the same cycle as the `meas_valid` pulse or the STALL entry that causes them.
- **Reset or `clear` mid-measurement:** the partial count is discarded and the next output needs a low level, a rise, then a second rise.

## Structure
- Shared package `clk_meas_pkg` holds:
  - the state enum (IDLE, ARM, MEASURE, STALL);
  - the `CNT_W` default constant;
  - the saturation constant.
- Sub-module `sync_edge_detect`: a `SYNC_STAGES`-deep synchronizer plus the `prev` flop, with outputs `s`, `rise` and `fall`. It is reusable by other blocks that sample external clocks.
- The top level contains the FSM, the counter, the capture registers and the lock compare.

## Test plan
- **Steady square wave:** reset, then toggle `sig_in` every 5 cycles (divider ratio 5).
  - `meas_valid` pulses every 10 cycles with `period=10`, `high_time=5`.
  - `locked=0` after the first pulse and 1 from the second pulse onward.
- **Minimum period:** toggle every cycle → `period=2`, `high_time=1`, `meas_valid` every 2 cycles, `locked=1` after the second pulse.
- **Saturation:** with `CNT_W=8`, hold `sig_in` low for 300 cycles after a rise.
  - `stalled=1` once `cnt=255`; no `meas_valid`; `locked=0`.
  - Then toggle every 4 cycles: the first rise gives no pulse and clears `stalled`; the second rise gives `period=8`.
- **Input high at reset release:** hold `sig_in=1` through reset release for 20 cycles, then toggle every 6 cycles. No pulse until after the second rise following the first low; that pulse carries `period=12`.
- **Period change:** while locked at `period=10`, stretch one high phase to 7 cycles.
  - Next pulse: `period=12`, `high_time=7`, `locked=0`.
  - Following pulse: `period=10`, `high_time=5`, `locked=0`.
  - The pulse after that: `locked=1`.
- **Clear collision:** assert `clear` in the same cycle as an internal `rise`. All outputs go to 0 and the edge is ignored; the first new pulse arrives only after the next low → rise → rise sequence.
